// File: rtl/vga_draw_arbiter.sv
// vga_draw_arbiter: round-robin owner of the single VGA pixel-write port.
// One drawer at a time gets a start pulse and keeps the port until done or watchdog expiry.
module vga_draw_arbiter #(
    parameter int NREQ           = 4,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int PTR_W          = 2
) (
    input  logic                  iCLOCK_50,
    input  logic                  iresetn,
    input  logic [NREQ-1:0]       iReq,
    input  logic [NREQ-1:0]       iDone,
    input  logic [9*NREQ-1:0]     ix,
    input  logic [8*NREQ-1:0]     iy,
    input  logic [3*NREQ-1:0]     icolor,
    input  logic [NREQ-1:0]       iwriteEn,
    output logic [NREQ-1:0]       oStart,
    output logic [NREQ-1:0]       oGrant,
    output logic [8:0]            ox,
    output logic [7:0]            oy,
    output logic [2:0]            ocolor,
    output logic                  owriteEn,
    output logic                  oBusy,
    output logic                  oTimeout
);

    localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_START   = 2'd1,
        S_ACTIVE  = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [PTR_W-1:0]  g_q, g_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic              to_q, to_d;
    logic              wd_expired_s;
    logic [8:0]        sel_x_s;
    logic [7:0]        sel_y_s;
    logic [2:0]        sel_c_s;
    logic              sel_we_s;

    // First set request bit scanning upward from ptr, wrapping at NREQ.
    function automatic logic [PTR_W-1:0] rr_pick(input logic [NREQ-1:0] req,
                                                 input logic [PTR_W-1:0] ptr);
        logic [PTR_W-1:0] pick;
        logic             found;
        int unsigned      k;
        pick  = '0;
        found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            k = (32'(ptr) + 32'(i)) % 32'(NREQ);
            if (!found && req[k]) begin
                pick  = PTR_W'(k);
                found = 1'b1;
            end else begin
                pick  = pick;
            end
        end
        return pick;
    endfunction

    assign wd_expired_s = (TIMEOUT_CYCLES != 0) && (wd_q == WD_W'(TIMEOUT_CYCLES - 1));
    assign sel_x_s      = ix[9*32'(g_q) +: 9];
    assign sel_y_s      = iy[8*32'(g_q) +: 8];
    assign sel_c_s      = icolor[3*32'(g_q) +: 3];
    assign sel_we_s     = iwriteEn[g_q];

    // State, grant index, pointer, watchdog and timeout-cause registers.
    always_ff @(posedge iCLOCK_50) begin
        if (!iresetn) begin
            state_q <= S_IDLE;
            g_q     <= '0;
            ptr_q   <= '0;
            wd_q    <= '0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            ptr_q   <= ptr_d;
            wd_q    <= wd_d;
            to_q    <= to_d;
        end
    end

    // Next-state: arbitration, ownership tracking and watchdog.
    always_comb begin
        state_d = state_q;
        g_d     = g_q;
        ptr_d   = ptr_q;
        wd_d    = wd_q;
        to_d    = to_q;
        case (state_q)
            S_IDLE: begin
                to_d = 1'b0;
                if (|iReq) begin
                    g_d     = rr_pick(iReq, ptr_q);
                    state_d = S_START;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                wd_d = '0;
                to_d = 1'b0;
                if (iDone[g_q]) begin
                    state_d = S_RELEASE;
                end else begin
                    state_d = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                wd_d = wd_q + WD_W'(1);
                // Done wins over a watchdog expiry in the same cycle.
                if (iDone[g_q]) begin
                    state_d = S_RELEASE;
                end else if (wd_expired_s) begin
                    state_d = S_RELEASE;
                    to_d    = 1'b1;
                end else begin
                    state_d = S_ACTIVE;
                end
            end
            S_RELEASE: begin
                state_d = S_IDLE;
                if (32'(g_q) == 32'(NREQ - 1)) begin
                    ptr_d = '0;
                end else begin
                    ptr_d = g_q + PTR_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output decode and pixel mux; only the owner reaches the VGA port.
    always_comb begin
        oStart   = '0;
        oGrant   = '0;
        ox       = 9'd0;
        oy       = 8'd0;
        ocolor   = 3'd0;
        owriteEn = 1'b0;
        oBusy    = 1'b0;
        oTimeout = 1'b0;
        case (state_q)
            S_IDLE: begin
                oBusy = 1'b0;
            end
            S_START: begin
                oStart[g_q] = 1'b1;
                oGrant[g_q] = 1'b1;
                oBusy       = 1'b1;
                ox          = sel_x_s;
                oy          = sel_y_s;
                ocolor      = sel_c_s;
                owriteEn    = sel_we_s;
            end
            S_ACTIVE: begin
                oGrant[g_q] = 1'b1;
                oBusy       = 1'b1;
                ox          = sel_x_s;
                oy          = sel_y_s;
                ocolor      = sel_c_s;
                owriteEn    = sel_we_s;
            end
            S_RELEASE: begin
                oBusy    = 1'b1;
                oTimeout = to_q;
            end
            default: begin
                oBusy = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_vga_draw_arbiter.sv
// Self-checking bench for vga_draw_arbiter (NREQ=4, watchdog of 16 cycles).
module tb_vga_draw_arbiter;

    localparam int N  = 4;
    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rstn;
    logic [3:0]  req, done, we;
    logic [35:0] ix;
    logic [31:0] iy;
    logic [11:0] ic;
    logic [3:0]  o_start, o_grant;
    logic [8:0]  ox;
    logic [7:0]  oy;
    logic [2:0]  oc;
    logic        owe, obusy, oto;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    vga_draw_arbiter #(.NREQ(4), .TIMEOUT_CYCLES(TO), .PTR_W(2)) dut (
        .iCLOCK_50(clk), .iresetn(rstn), .iReq(req), .iDone(done),
        .ix(ix), .iy(iy), .icolor(ic), .iwriteEn(we),
        .oStart(o_start), .oGrant(o_grant), .ox(ox), .oy(oy), .ocolor(oc),
        .owriteEn(owe), .oBusy(obusy), .oTimeout(oto)
    );

    typedef struct {
        logic [3:0] req;
        logic [3:0] done;
        logic [3:0] we;
        logic [3:0] st;
        logic [3:0] gr;
        logic       busy;
        int         src;
    } vec_t;

    vec_t vecs[13];
    int   dx[4] = '{10, 200, 298, 5};
    int   dy[4] = '{20, 40, 122, 86};
    int   dc[4] = '{1, 2, 7, 4};

    // Reference model: who owns the port, for how long, and release bookkeeping.
    int   m_owner, m_age, m_ptr;
    bit   m_rel, m_to;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [30:0] act_out();
        return {o_start, o_grant, ox, oy, oc, owe, obusy, oto};
    endfunction

    function automatic logic [30:0] exp_out(int src, logic [3:0] st, logic [3:0] gr,
                                            logic busy, logic t);
        logic [8:0] x;
        logic [7:0] y;
        logic [2:0] c;
        logic       w;
        x = 9'd0; y = 8'd0; c = 3'd0; w = 1'b0;
        if (src >= 0) begin
            x = ix[9*src +: 9];
            y = iy[8*src +: 8];
            c = ic[3*src +: 3];
            w = we[src];
        end
        return {st, gr, x, y, c, w, busy, t};
    endfunction

    function automatic vec_t mk(logic [3:0] r, logic [3:0] d, logic [3:0] w,
                                logic [3:0] s, logic [3:0] g, logic b, int src);
        vec_t v;
        v.req = r; v.done = d; v.we = w; v.st = s; v.gr = g; v.busy = b; v.src = src;
        return v;
    endfunction

    task automatic set_fixed_data();
        for (int k = 0; k < N; k++) begin
            ix[9*k +: 9] = 9'(dx[k]);
            iy[8*k +: 8] = 8'(dy[k]);
            ic[3*k +: 3] = 3'(dc[k]);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0; req = 4'd0; done = 4'd0; we = 4'd0;
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic model_step();
        if (!rstn) begin
            m_owner = -1; m_rel = 1'b0; m_to = 1'b0; m_ptr = 0;
        end else if (m_owner >= 0) begin
            if (done[m_owner]) begin
                m_rel = 1'b1; m_to = 1'b0; m_ptr = (m_owner + 1) % N; m_owner = -1;
            end else if (m_age >= TO) begin
                m_rel = 1'b1; m_to = 1'b1; m_ptr = (m_owner + 1) % N; m_owner = -1;
            end else begin
                m_age++;
            end
        end else if (m_rel) begin
            m_rel = 1'b0; m_to = 1'b0;
        end else if (req != 4'd0) begin
            for (int i = 0; i < N; i++) begin
                if (m_owner < 0 && req[(m_ptr + i) % N]) m_owner = (m_ptr + i) % N;
            end
            m_age = 0;
        end
    endtask

    initial begin
        int own, st, n, cyc, s0, s1, to_cnt, to_cyc;
        logic [3:0] gr_at_to;
        logic [3:0] oh;

        rstn = 1'b0; req = 4'd0; done = 4'd0; we = 4'd0;
        ix = '0; iy = '0; ic = '0;

        vecs[0]  = mk(4'b0000, 4'b0000, 4'b1100, 4'b0000, 4'b0000, 1'b0, -1);
        vecs[1]  = mk(4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, -1);
        vecs[2]  = mk(4'b0100, 4'b0000, 4'b1100, 4'b0100, 4'b0100, 1'b1, 2);
        vecs[3]  = mk(4'b0000, 4'b1011, 4'b1000, 4'b0000, 4'b0100, 1'b1, 2);
        vecs[4]  = mk(4'b0000, 4'b0000, 4'b0100, 4'b0000, 4'b0100, 1'b1, 2);
        vecs[5]  = mk(4'b0000, 4'b0100, 4'b1100, 4'b0000, 4'b0100, 1'b1, 2);
        vecs[6]  = mk(4'b0000, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 1'b1, -1);
        vecs[7]  = mk(4'b0000, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 1'b0, -1);
        vecs[8]  = mk(4'b1001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, -1);
        vecs[9]  = mk(4'b1001, 4'b1000, 4'b1000, 4'b1000, 4'b1000, 1'b1, 3);
        vecs[10] = mk(4'b1001, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 1'b1, -1);
        vecs[11] = mk(4'b1001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, -1);
        vecs[12] = mk(4'b0010, 4'b0000, 4'b0001, 4'b0001, 4'b0001, 1'b1, 0);

        // Idle after reset: nothing may leak to the VGA port.
        do_reset();
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            req = 4'd0; done = 4'd0; we = 4'b1111;
            ix = 36'({$urandom(), $urandom()}); iy = $urandom(); ic = 12'($urandom());
            #1;
            chk("idle", 64'(act_out()), 64'd0);
        end

        // Directed table: single owner, foreign writes/done, start-cycle done, pointer wrap.
        do_reset();
        set_fixed_data();
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            req = vecs[i].req; done = vecs[i].done; we = vecs[i].we;
            #1;
            chk($sformatf("vec[%0d]", i), 64'(act_out()),
                64'(exp_out(vecs[i].src, vecs[i].st, vecs[i].gr, vecs[i].busy, 1'b0)));
        end

        // All four requesting; done 5 cycles after each start.
        do_reset();
        req = 4'b1111;
        own = -1; st = 0; n = 0; cyc = 0;
        while (n < 5 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            done = 4'd0;
            if (own >= 0 && cyc == st + 5) done[own] = 1'b1;
            #1;
            if (o_start != 4'd0) begin
                oh = o_start;
                own = -1;
                for (int k = 0; k < N; k++) if (oh[k]) own = k;
                chk("rr_order", 64'(own), 64'(n % N));
                if (n > 0) chk("rr_gap", 64'(cyc - st), 64'd8);
                st = cyc;
                n++;
            end
        end
        chk("rr_count", 64'(n), 64'd5);
        req = 4'd0; done = 4'd0;

        // Watchdog: drawer 0 never finishes, drawer 1 waits.
        do_reset();
        s0 = -1; s1 = -1; to_cnt = 0; to_cyc = -1; gr_at_to = 4'hF;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            req = 4'b0011; done = 4'd0;
            #1;
            if (oto) begin
                to_cnt++; to_cyc = c; gr_at_to = o_grant;
            end
            if (o_start == 4'b0001 && s0 < 0) s0 = c;
            if (o_start == 4'b0010 && s1 < 0) s1 = c;
        end
        chk("to_start0", 64'(s0 >= 0), 64'd1);
        chk("to_pulses", 64'(to_cnt), 64'd1);
        chk("to_when", 64'(to_cyc - s0), 64'd17);
        chk("to_grant", 64'(gr_at_to), 64'd0);
        chk("to_next1", 64'(s1 - s0), 64'd19);
        req = 4'd0;

        // Reset during drawer 2's ownership.
        do_reset();
        repeat (4) begin
            @(negedge clk);
            req = 4'b0100;
        end
        #1;
        chk("rst_pre_grant", 64'(o_grant), 64'(4'b0100));
        @(negedge clk);
        rstn = 1'b0; req = 4'b0101; we = 4'b1111;
        @(negedge clk);
        rstn = 1'b1;
        #1;
        chk("rst_mid", 64'(act_out()), 64'd0);
        @(negedge clk);
        #1;
        chk("rst_then0", 64'(o_start), 64'(4'b0001));

        // Randomized run against the reference model.
        do_reset();
        m_owner = -1; m_age = 0; m_ptr = 0; m_rel = 1'b0; m_to = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            rstn = ($urandom_range(0, 299) != 0);
            req  = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom());
            for (int k = 0; k < N; k++) done[k] = ($urandom_range(0, 9) == 0);
            we = 4'($urandom());
            ix = 36'({$urandom(), $urandom()}); iy = $urandom(); ic = 12'($urandom());
            #1;
            chk("rand", 64'(act_out()),
                64'(exp_out(m_owner,
                            (m_owner >= 0 && m_age == 0) ? 4'(1 << m_owner) : 4'd0,
                            (m_owner >= 0) ? 4'(1 << m_owner) : 4'd0,
                            (m_owner >= 0) || m_rel,
                            m_rel && m_to)));
            @(posedge clk);
            model_step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vga_draw_arbiter.md
Name: vga_draw_arbiter

Overview:
- Shares the single VGA pixel-write port between NREQ sprite/erase drawer FSMs: tanks, bullets, heart erase, score.
- Each drawer requests, receives a one-cycle start pulse, owns the port until it pulses done, then is released.
- Round-robin fairness; optional watchdog frees the port if a drawer hangs.
- Sits between the drawer blocks and the vga_adapter pixel inputs.

Parameters:
NREQ, 4, number of requesters (2..8)
TIMEOUT_CYCLES, 4096, max cycles a grant may stay in ACTIVE; 0 disables the watchdog
PTR_W, 2, width of grant index / RR pointer (ceil(log2(NREQ)))

Ports:
iCLOCK_50  input  1  system clock, all logic on rising edge
iresetn  input  1  synchronous active-low reset
iReq  input  NREQ  level request per drawer, held until its grant/start
iDone  input  NREQ  per-drawer done pulse; only the granted bit is honoured
ix  input  9*NREQ  packed drawer x, requester k at bits [9k+8:9k]
iy  input  8*NREQ  packed drawer y, [8k+7:8k]
icolor  input  3*NREQ  packed drawer color, [3k+2:3k]
iwriteEn  input  NREQ  drawer pixel write enables
oStart  output  NREQ  one-hot, one-cycle start pulse to the winner
oGrant  output  NREQ  one-hot, high in START and ACTIVE
ox  output  9  muxed x to VGA
oy  output  8  muxed y to VGA
ocolor  output  3  muxed color to VGA
owriteEn  output  1  muxed write enable to VGA
oBusy  output  1  high in every state except IDLE
oTimeout  output  1  one-cycle pulse when the watchdog forces a release

Behaviour:
- Reset (iresetn=0 at a clock edge): state=IDLE, pointer=0, grant index=0, watchdog=0. Next cycle all outputs are 0: oStart, oGrant, ox, oy, ocolor, owriteEn, oBusy, oTimeout. Reset mid-grant aborts with no done and no timeout pulse.
- States are IDLE, START, ACTIVE, RELEASE. State, grant index, pointer and watchdog are registered. Outputs decode combinationally from state and grant index g.
- IDLE:
  - If iReq != 0, pick the first set bit scanning g = pointer, pointer+1, … modulo NREQ.
  - Register g, go to START. Otherwise stay in IDLE.
- START, one cycle:
  - oStart[g]=1, oGrant[g]=1, watchdog cleared.
  - If iDone[g]=1, go to RELEASE. Otherwise go to ACTIVE.
- ACTIVE:
  - oGrant[g]=1; watchdog increments every cycle.
  - If iDone[g]=1, go to RELEASE.
  - Else if TIMEOUT_CYCLES != 0 and watchdog == TIMEOUT_CYCLES-1, go to RELEASE and flag timeout.
  - iDone takes precedence over the watchdog in the same cycle.
- RELEASE, one cycle:
  - oGrant=0, owriteEn=0.
  - pointer = (g+1) mod NREQ.
  - oTimeout=1 only if entered via the watchdog.
  - Go to IDLE.
- Datapath mux:
  - In START/ACTIVE: ox/oy/ocolor/owriteEn equal requester g's slice, combinational, 0 cycles added latency.
  - In IDLE/RELEASE: all four are 0.
  - Writes from non-granted drawers never reach the VGA port.
- Latency:
  - iReq seen in IDLE at edge t gives oStart at t+1.
  - Done at cycle d gives RELEASE at d+1, IDLE at d+2, next START at d+3. Minimum 3-cycle gap between owners.
- Boundary cases:
  - iDone of a non-granted bit: ignored.
  - iReq dropping while granted: ignored; the grant lasts until done or timeout.
  - Requests arriving during START/ACTIVE/RELEASE: queue implicitly on the level iReq.
  - Pointer wrap: NREQ-1 wraps to 0.
  - Single requester holding iReq: re-granted every 3+ cycles.
  - Pointer indices ≥ NREQ are unreachable.

Test Plan:
- Reset, then iReq=4'b0000 for 20 cycles -> oBusy=0, owriteEn=0, ox=0, oy=0, ocolor=0 throughout.
- iReq=4'b0100 at t → oStart=4'b0100 at t+1 only. Drawer 2 drives x=298,y=122,color=3'b111,we=1 → ox=298,oy=122,ocolor=7,owriteEn=1 same cycle. Done at d → oGrant=0 at d+1, oBusy=0 at d+2.
- iReq=4'b1111 held, each drawer pulses done 5 cycles after its start → grant order 0,1,2,3,0; every owner change has a 3-cycle gap.
- Drawer 1 granted while drawer 3 drives iwriteEn=1 with x=5,y=86 → ox/oy track drawer 1 only; drawer 3's pixels never appear.
- TIMEOUT_CYCLES=16, drawer 0 granted and never signals done → release after 16 ACTIVE cycles; oTimeout=1 for exactly 1 cycle; pointer=1; pending drawer 1 starts next.
- iresetn=0 for one cycle mid-ACTIVE of drawer 2 → all outputs 0 next cycle, no oTimeout; drawer 0 requested afterwards wins before drawer 2.
